pio_access_arbiter: RTL and testbench

Two-requester Avalon-MM arbiter that shares one 32-bit PIO output-register slave, such as the LED PIO, between the PCIe host bridge (m0) and a local pattern/animation engine (m1). It sits between both masters and the PIO slave port. It serialises single-word reads and writes with waitrequest back-pressure, using round-robin or fixed priority. The PIO slave has zero read latency and no waitrequest; this block supplies the flow control.

---
 rtl/pio_arb_pkg.sv | 19 +
 rtl/pio_arb_pick.sv | 26 ++
 rtl/pio_access_arbiter.sv | 114 +++++++++++
 tb/tb_pio_access_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_arb_pkg.sv
// Shared types and constants for the PIO access arbiter.
// Holds the FSM state encoding, master (owner) encoding and counter width.
// Imported by the arbiter top level and its winner-selection helper.
package pio_arb_pkg;

  // Arbiter FSM: IDLE waits for a request, SERVE is the single completion cycle
  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  // Owner / last-served encoding
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // Width of the per-master completed-transfer counters
  localparam int CNT_W = 16;

endpackage

// File: rtl/pio_arb_pick.sv
// Winner selection for the PIO arbiter, purely combinational.
// Round-robin favours the master that was not served last; fixed priority
// always favours m0. Only meaningful when at least one request is high.
module pio_arb_pick #(
  parameter int FIXED_PRIO = 0
) (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic winner
);
  import pio_arb_pkg::*;

  // Choose the next owner from the current requests and the last-served master
  always_comb begin
    winner = M0;
    if (FIXED_PRIO != 0) begin
      winner = req0 ? M0 : M1;
    end else if (req0 && req1) begin
      winner = (last == M0) ? M1 : M0;
    end else begin
      winner = req0 ? M0 : M1;
    end
  end

endmodule

// File: rtl/pio_access_arbiter.sv
// Two-master Avalon-MM arbiter in front of a zero-latency PIO register slave.
// A request seen in IDLE completes on the next cycle; waiting masters alternate
// back-to-back. Flow control is waitrequest only; no data path is registered.
module pio_access_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 2,
  parameter int FIXED_PRIO = 0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          m0_chipselect,
  input  logic                          m0_write_n,
  input  logic [ADDR_W-1:0]             m0_address,
  input  logic [DATA_W-1:0]             m0_writedata,
  output logic [DATA_W-1:0]             m0_readdata,
  output logic                          m0_waitrequest,
  input  logic                          m1_chipselect,
  input  logic                          m1_write_n,
  input  logic [ADDR_W-1:0]             m1_address,
  input  logic [DATA_W-1:0]             m1_writedata,
  output logic [DATA_W-1:0]             m1_readdata,
  output logic                          m1_waitrequest,
  output logic                          s_chipselect,
  output logic                          s_write_n,
  output logic [ADDR_W-1:0]             s_address,
  output logic [DATA_W-1:0]             s_writedata,
  input  logic [DATA_W-1:0]             s_readdata,
  output logic [1:0]                    grant,
  output logic [pio_arb_pkg::CNT_W-1:0] xfer_cnt0,
  output logic [pio_arb_pkg::CNT_W-1:0] xfer_cnt1
);
  import pio_arb_pkg::*;

  state_t           state;
  logic             owner;
  logic             last;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
  logic             pick;
  logic             serve0;
  logic             serve1;
  logic             owner_cs;
  logic             other_cs;

  pio_arb_pick #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_pick (
    .req0   (m0_chipselect),
    .req1   (m1_chipselect),
    .last   (last),
    .winner (pick)
  );

  assign serve0   = (state == SERVE) && (owner == M0);
  assign serve1   = (state == SERVE) && (owner == M1);
  assign owner_cs = (owner == M0) ? m0_chipselect : m1_chipselect;
  assign other_cs = (owner == M0) ? m1_chipselect : m0_chipselect;

  // Arbitration FSM: grant in IDLE, complete in SERVE, hand over directly to a
  // waiting non-owner. The owner's own chipselect during its completion cycle
  // is never taken as a fresh request, so neither master can monopolise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      owner <= M0;
      last  <= M1;
      cnt0  <= '0;
      cnt1  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_chipselect || m1_chipselect) begin
            state <= SERVE;
            owner <= pick;
          end
        end
        SERVE: begin
          last <= owner;
          // A master that withdrew its request mid-wait gets a dead cycle, not a count
          if (owner_cs) begin
            if (owner == M0) cnt0 <= cnt0 + 1'b1;
            else             cnt1 <= cnt1 + 1'b1;
          end
          if (other_cs) owner <= ~owner;
          else          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Slave-side mux: only the owner's signals reach the PIO, idle values otherwise
  always_comb begin
    s_chipselect = 1'b0;
    s_write_n    = 1'b1;
    s_address    = '0;
    s_writedata  = '0;
    if (state == SERVE) begin
      s_chipselect = owner_cs;
      s_write_n    = (owner == M0) ? m0_write_n   : m1_write_n;
      s_address    = (owner == M0) ? m0_address   : m1_address;
      s_writedata  = (owner == M0) ? m0_writedata : m1_writedata;
    end
  end

  assign m0_waitrequest = ~serve0;
  assign m1_waitrequest = ~serve1;
  assign m0_readdata    = serve0 ? s_readdata : '0;
  assign m1_readdata    = serve1 ? s_readdata : '0;
  assign grant          = {serve1, serve0};
  assign xfer_cnt0      = cnt0;
  assign xfer_cnt1      = cnt1;

endmodule

// File: tb/tb_pio_access_arbiter.sv
// Bench for pio_access_arbiter: round-robin instance checked every cycle
// against a transaction-level model plus directed literals; a fixed-priority
// instance checked against a hand-computed grant table.
module tb_pio_access_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // ---------------- round-robin instance ----------------
  logic        m0_chipselect = 0, m0_write_n = 1, m1_chipselect = 0, m1_write_n = 1;
  logic [1:0]  m0_address = 0, m1_address = 0;
  logic [31:0] m0_writedata = 0, m1_writedata = 0;
  logic [31:0] m0_readdata, m1_readdata, s_writedata, s_readdata;
  logic        m0_waitrequest, m1_waitrequest, s_chipselect, s_write_n;
  logic [1:0]  s_address, grant;
  logic [15:0] xfer_cnt0, xfer_cnt1;

  pio_access_arbiter #(.DATA_W(32), .ADDR_W(2), .FIXED_PRIO(0)) u_rr (
    .clk(clk), .reset_n(reset_n),
    .m0_chipselect(m0_chipselect), .m0_write_n(m0_write_n), .m0_address(m0_address),
    .m0_writedata(m0_writedata), .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
    .m1_chipselect(m1_chipselect), .m1_write_n(m1_write_n), .m1_address(m1_address),
    .m1_writedata(m1_writedata), .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
    .s_chipselect(s_chipselect), .s_write_n(s_write_n), .s_address(s_address),
    .s_writedata(s_writedata), .s_readdata(s_readdata), .grant(grant),
    .xfer_cnt0(xfer_cnt0), .xfer_cnt1(xfer_cnt1)
  );

  // PIO slave model: zero read latency, not affected by arbiter reset
  logic [31:0] pio [4] = '{32'h0005AAAA, 32'h0, 32'h0BADF00D, 32'h0};
  assign s_readdata = pio[s_address];
  always @(posedge clk) if (s_chipselect && !s_write_n) pio[s_address] <= s_writedata;

  // ---------------- fixed-priority instance ----------------
  logic        f_m0_cs = 0, f_m1_cs = 0;
  logic [31:0] f_m0_rd, f_m1_rd, f_s_wd;
  logic        f_m0_wr, f_m1_wr, f_s_cs, f_s_wn;
  logic [1:0]  f_s_addr, f_grant;
  logic [15:0] f_cnt0, f_cnt1;

  pio_access_arbiter #(.DATA_W(32), .ADDR_W(2), .FIXED_PRIO(1)) u_fp (
    .clk(clk), .reset_n(reset_n),
    .m0_chipselect(f_m0_cs), .m0_write_n(1'b1), .m0_address(2'd0),
    .m0_writedata(32'h0), .m0_readdata(f_m0_rd), .m0_waitrequest(f_m0_wr),
    .m1_chipselect(f_m1_cs), .m1_write_n(1'b1), .m1_address(2'd0),
    .m1_writedata(32'h0), .m1_readdata(f_m1_rd), .m1_waitrequest(f_m1_wr),
    .s_chipselect(f_s_cs), .s_write_n(f_s_wn), .s_address(f_s_addr),
    .s_writedata(f_s_wd), .s_readdata(32'hC0FFEE00), .grant(f_grant),
    .xfer_cnt0(f_cnt0), .xfer_cnt1(f_cnt1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model of the round-robin instance ----------------
  // srv = master whose transfer completes this cycle, -1 when nobody is served
  int          srv = -1;
  logic        mlast = 1'b1;
  logic [15:0] mcnt [2] = '{16'd0, 16'd0};
  logic [1:0]  csv;
  assign csv = {m1_chipselect, m0_chipselect};

  // Advance the model: a served master finishes and a waiting other master takes over
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      srv     <= -1;
      mlast   <= 1'b1;
      mcnt[0] <= 16'd0;
      mcnt[1] <= 16'd0;
    end else if (srv >= 0) begin
      if (csv[srv]) mcnt[srv] <= mcnt[srv] + 16'd1;
      mlast <= (srv == 1);
      srv   <= csv[1-srv] ? 1 - srv : -1;
    end else if (csv != 2'b00) begin
      srv <= (csv == 2'b11) ? (mlast ? 0 : 1) : (csv[0] ? 0 : 1);
    end
  end

  // Compare every DUT output with the model mid-cycle
  always @(negedge clk) begin
    logic        own_cs, own_wn;
    logic [1:0]  own_a;
    logic [31:0] own_d;
    if (chk_en) begin
      own_cs = (srv == 0) ? m0_chipselect : m1_chipselect;
      own_wn = (srv == 0) ? m0_write_n    : m1_write_n;
      own_a  = (srv == 0) ? m0_address    : m1_address;
      own_d  = (srv == 0) ? m0_writedata  : m1_writedata;
      chk("cmp_grant", grant, (srv < 0) ? 2'b00 : ((srv == 0) ? 2'b01 : 2'b10));
      chk("cmp_m0_wait", m0_waitrequest, srv != 0);
      chk("cmp_m1_wait", m1_waitrequest, srv != 1);
      chk("cmp_m0_rdata", m0_readdata, (srv == 0) ? pio[m0_address] : 32'h0);
      chk("cmp_m1_rdata", m1_readdata, (srv == 1) ? pio[m1_address] : 32'h0);
      chk("cmp_s_cs", s_chipselect, (srv >= 0) && own_cs);
      chk("cmp_s_wn", s_write_n, (srv < 0) ? 1'b1 : own_wn);
      chk("cmp_s_addr", s_address, (srv < 0) ? 2'd0 : own_a);
      chk("cmp_s_wdata", s_writedata, (srv < 0) ? 32'h0 : own_d);
      chk("cmp_cnt0", xfer_cnt0, mcnt[0]);
      chk("cmp_cnt1", xfer_cnt1, mcnt[1]);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  logic [1:0] fp_tab [12] = '{2'b01, 2'b10, 2'b01, 2'b00, 2'b01, 2'b10,
                              2'b01, 2'b00, 2'b01, 2'b10, 2'b01, 2'b00};
  bit         fp_cs1 [12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1,
                              1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    int cur_wait, max_wait;
    // Reset state
    #1 reset_n = 1'b0;
    step(2);
    chk("rst_grant", grant, 2'b00);
    chk("rst_m0_wait", m0_waitrequest, 1'b1);
    chk("rst_m1_wait", m1_waitrequest, 1'b1);
    chk("rst_s_cs", s_chipselect, 1'b0);
    chk("rst_s_wn", s_write_n, 1'b1);
    chk("rst_cnt0", xfer_cnt0, 16'd0);
    chk_en  = 1'b1;
    reset_n = 1'b1;
    step(1);

    // m0 single read: one wait cycle, then the PIO reset value
    m0_chipselect = 1; m0_write_n = 1; m0_address = 2'd0;
    chk("t1_wait_pre", m0_waitrequest, 1'b1);
    step(1);
    chk("t1_wait_done", m0_waitrequest, 1'b0);
    chk("t1_rdata", m0_readdata, 32'h0005AAAA);
    chk("t1_grant", grant, 2'b01);
    step(1);
    m0_chipselect = 0;
    chk("t1_cnt0", xfer_cnt0, 16'd1);
    chk("t1_idle_grant", grant, 2'b00);

    // Simultaneous m0 write / m1 read after reset: m0 first, m1 sees the new value next cycle
    do_reset();
    m0_chipselect = 1; m0_write_n = 0; m0_address = 2'd0; m0_writedata = 32'h000000FF;
    m1_chipselect = 1; m1_write_n = 1; m1_address = 2'd0;
    step(1);
    chk("t2_grant_m0", grant, 2'b01);
    chk("t2_s_wdata", s_writedata, 32'h000000FF);
    step(1);
    m0_chipselect = 0; m0_write_n = 1;
    chk("t2_grant_m1", grant, 2'b10);
    chk("t2_m1_rdata", m1_readdata, 32'h000000FF);
    step(1);
    m1_chipselect = 0;
    chk("t2_cnt0", xfer_cnt0, 16'd1);
    chk("t2_cnt1", xfer_cnt1, 16'd1);

    // Both streaming: strict alternation, no idle gap
    do_reset();
    m0_chipselect = 1; m0_write_n = 0; m0_address = 2'd1; m0_writedata = 32'h11111111;
    m1_chipselect = 1; m1_write_n = 1; m1_address = 2'd2;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("t3_grant_seq", grant, (i % 2 == 0) ? 2'b01 : 2'b10);
    end
    m0_chipselect = 0; m0_write_n = 1;
    step(1);
    m1_chipselect = 0;
    chk("t3_cnt0", xfer_cnt0, 16'd4);
    chk("t3_cnt1", xfer_cnt1, 16'd4);
    chk("t3_pio1", pio[1], 32'h11111111);

    // Reset in the middle of an m1 write SERVE cycle
    m1_chipselect = 1; m1_write_n = 0; m1_address = 2'd0; m1_writedata = 32'h12345678;
    step(1);
    chk("t5_s_cs_serve", s_chipselect, 1'b1);
    chk("t5_s_wdata_serve", s_writedata, 32'h12345678);
    #1 reset_n = 1'b0;
    #1;
    chk("t5_s_cs_drop", s_chipselect, 1'b0);
    chk("t5_grant_drop", grant, 2'b00);
    chk("t5_m1_wait", m1_waitrequest, 1'b1);
    chk("t5_s_wdata_drop", s_writedata, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    m1_chipselect = 0; m1_write_n = 1;
    chk("t5_pio_kept", pio[0], 32'h000000FF);
    chk("t5_cnt1", xfer_cnt1, 16'd0);
    m0_chipselect = 1; m1_chipselect = 1;
    step(1);
    chk("t5_m0_wins", grant, 2'b01);
    step(1);
    m0_chipselect = 0;
    step(1);
    m1_chipselect = 0;

    // Fixed priority: m0 streams, m1 never waits more than two cycles
    do_reset();
    f_m0_cs = 1; f_m1_cs = 1;
    cur_wait = 1; max_wait = 1;
    for (int e = 0; e < 12; e++) begin
      step(1);
      chk("fp_grant", f_grant, fp_tab[e]);
      f_m1_cs = fp_cs1[e];
      if (e == 11) f_m0_cs = 0;
      if (f_m1_cs && f_m1_wr) cur_wait++;
      else cur_wait = 0;
      if (cur_wait > max_wait) max_wait = cur_wait;
    end
    chk("fp_cnt0", f_cnt0, 16'd6);
    chk("fp_cnt1", f_cnt1, 16'd3);
    tests++;
    if (max_wait > 2) begin
      fails++;
      $display("FAIL fp_m1_max_wait: got %0d cycles, required at most 2", max_wait);
    end

    // Counter wrap: 65535 m0 transfers, then one more
    do_reset();
    m1_chipselect = 1; m1_write_n = 1; m1_address = 2'd2;
    step(2);
    m1_chipselect = 0;
    chk("t6_cnt1_pre", xfer_cnt1, 16'd1);
    m0_chipselect = 1; m0_write_n = 1; m0_address = 2'd3;
    step(2 * 65535);
    chk("t6_cnt0_full", xfer_cnt0, 16'hFFFF);
    step(2);
    m0_chipselect = 0;
    chk("t6_cnt0_wrap", xfer_cnt0, 16'h0000);
    chk("t6_cnt1_kept", xfer_cnt1, 16'd1);
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
